// File: rtl/spec_mem_sequencer.sv
// spec_mem_sequencer: issues one multi-granule spec memory operation as a
// sequence of single-word transactions on an Ibex-style req/gnt/rvalid
// data interface, collecting read data and capability tags.
// Optional revocation lookup for tagged capability loads is compiled in
// when the macro SPEC_MEM_REVOKE_EN is defined.
module spec_mem_sequencer #(
   parameter int NGRAN = 2,
   parameter int GW    = $clog2(NGRAN + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic                is_write_i,
   input  logic                is_cap_i,
   input  logic [GW-1:0]       ngran_i,
   input  logic [NGRAN*32-1:0] addr_i,
   input  logic [NGRAN*32-1:0] wdata_i,
   input  logic [NGRAN*4-1:0]  be_i,
   input  logic                wtag_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o,
   output logic [NGRAN*32-1:0] rdata_o,
   output logic                rtag_o,
   output logic                revoked_o,
   output logic                data_req_o,
   input  logic                data_gnt_i,
   output logic                data_we_o,
   output logic [3:0]          data_be_o,
   output logic [31:0]         data_addr_o,
   output logic [31:0]         data_wdata_o,
   output logic                data_wtag_o,
   input  logic                data_rvalid_i,
   input  logic [31:0]         data_rdata_i,
   input  logic                data_rtag_i,
   input  logic                data_err_i,
   output logic                rev_req_o,
   output logic [31:0]         rev_addr_o,
   input  logic                rev_valid_i,
   input  logic                rev_bit_i
);

   // Index width for granule selection; at least one bit even for NGRAN==1.
   localparam int KW = (NGRAN > 1) ? $clog2(NGRAN) : 1;
   localparam logic [GW-1:0] NGRAN_W = GW'(NGRAN);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
`ifdef SPEC_MEM_REVOKE_EN
      ST_REV,
`endif
      ST_DONE
   } state_t;

   state_t state_reg;

   // Operation context captured at start.
   logic [KW-1:0]       k_reg;
   logic [KW-1:0]       last_k_reg;
   logic                is_write_reg;
   logic                is_cap_reg;
   logic                wtag_reg;
   logic [NGRAN*32-1:0] addr_reg;
   logic [NGRAN*32-1:0] wdata_reg;
   logic [NGRAN*4-1:0]  be_reg;
   logic                acc_tag_reg;

   // Registered outputs.
   logic                busy_reg;
   logic                done_reg;
   logic                err_reg;
   logic                rtag_reg;
   logic [31:0]         rdata_reg [NGRAN];
   logic                req_reg;
   logic                we_reg;
   logic [3:0]          bus_be_reg;
   logic [31:0]         bus_addr_reg;
   logic [31:0]         bus_wdata_reg;
   logic                bus_wtag_reg;

   // Per-granule views of the latched operation.
   logic [31:0]         addr_lat  [NGRAN];
   logic [31:0]         wdata_lat [NGRAN];
   logic [3:0]          be_lat    [NGRAN];
   logic [KW-1:0]       k_inc;

   assign k_inc = k_reg + 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < NGRAN; gi++) begin : g_gran
         assign addr_lat[gi]          = addr_reg[gi*32 +: 32];
         assign wdata_lat[gi]         = wdata_reg[gi*32 +: 32];
         assign be_lat[gi]            = be_reg[gi*4 +: 4];
         assign rdata_o[gi*32 +: 32]  = rdata_reg[gi];
      end
   endgenerate

`ifdef SPEC_MEM_REVOKE_EN
   logic        rev_req_reg;
   logic [31:0] rev_addr_reg;
   logic        revoked_reg;
`endif

   // Main sequencer: one granule in flight at a time, all outputs registered.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg     <= ST_IDLE;
         k_reg         <= '0;
         last_k_reg    <= '0;
         is_write_reg  <= 1'b0;
         is_cap_reg    <= 1'b0;
         wtag_reg      <= 1'b0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         be_reg        <= '0;
         acc_tag_reg   <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
         rtag_reg      <= 1'b0;
         for (int i = 0; i < NGRAN; i++) rdata_reg[i] <= '0;
         req_reg       <= 1'b0;
         we_reg        <= 1'b0;
         bus_be_reg    <= '0;
         bus_addr_reg  <= '0;
         bus_wdata_reg <= '0;
         bus_wtag_reg  <= 1'b0;
`ifdef SPEC_MEM_REVOKE_EN
         rev_req_reg   <= 1'b0;
         rev_addr_reg  <= '0;
         revoked_reg   <= 1'b0;
`endif
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start_i) begin
                  busy_reg <= 1'b1;
                  rtag_reg <= 1'b0;
`ifdef SPEC_MEM_REVOKE_EN
                  revoked_reg <= 1'b0;
`endif
                  if (ngran_i == '0) begin
                     // Empty operation completes without touching the bus.
                     err_reg   <= 1'b0;
                     done_reg  <= 1'b1;
                     state_reg <= ST_DONE;
                  end else if (ngran_i > NGRAN_W) begin
                     // Oversized request is rejected without touching the bus.
                     err_reg   <= 1'b1;
                     done_reg  <= 1'b1;
                     state_reg <= ST_DONE;
                  end else begin
                     k_reg         <= '0;
                     last_k_reg    <= KW'(ngran_i - 1'b1);
                     is_write_reg  <= is_write_i;
                     is_cap_reg    <= is_cap_i;
                     wtag_reg      <= wtag_i;
                     addr_reg      <= addr_i;
                     wdata_reg     <= wdata_i;
                     be_reg        <= be_i;
                     acc_tag_reg   <= is_cap_i & ~is_write_i;
                     err_reg       <= 1'b0;
                     for (int i = 0; i < NGRAN; i++) rdata_reg[i] <= '0;
                     // Granule 0 comes straight from the inputs being latched.
                     req_reg       <= 1'b1;
                     we_reg        <= is_write_i;
                     bus_addr_reg  <= addr_i[31:0];
                     bus_wdata_reg <= wdata_i[31:0];
                     bus_be_reg    <= is_cap_i ? 4'hF : be_i[3:0];
                     bus_wtag_reg  <= is_cap_i & is_write_i & wtag_i;
                     state_reg     <= ST_REQ;
                  end
               end
            end

            ST_REQ: begin
               if (data_gnt_i) begin
                  req_reg   <= 1'b0;
                  state_reg <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (data_rvalid_i) begin
                  if (!is_write_reg) rdata_reg[k_reg] <= data_rdata_i;
                  acc_tag_reg <= acc_tag_reg & data_rtag_i;
                  if (data_err_i) begin
                     err_reg   <= 1'b1;
                     done_reg  <= 1'b1;
                     state_reg <= ST_DONE;
                  end else if (k_reg == last_k_reg) begin
                     rtag_reg <= is_cap_reg & ~is_write_reg & acc_tag_reg & data_rtag_i;
`ifdef SPEC_MEM_REVOKE_EN
                     if (is_cap_reg && !is_write_reg && acc_tag_reg && data_rtag_i) begin
                        rev_req_reg  <= 1'b1;
                        rev_addr_reg <= addr_lat[0];
                        state_reg    <= ST_REV;
                     end else begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                     end
`else
                     done_reg  <= 1'b1;
                     state_reg <= ST_DONE;
`endif
                  end else begin
                     k_reg         <= k_inc;
                     req_reg       <= 1'b1;
                     bus_addr_reg  <= addr_lat[k_inc];
                     bus_wdata_reg <= wdata_lat[k_inc];
                     bus_be_reg    <= is_cap_reg ? 4'hF : be_lat[k_inc];
                     bus_wtag_reg  <= is_cap_reg & is_write_reg & wtag_reg;
                     state_reg     <= ST_REQ;
                  end
               end
            end

`ifdef SPEC_MEM_REVOKE_EN
            ST_REV: begin
               if (rev_valid_i) begin
                  revoked_reg  <= rev_bit_i;
                  rev_req_reg  <= 1'b0;
                  rev_addr_reg <= '0;
                  done_reg     <= 1'b1;
                  state_reg    <= ST_DONE;
               end
            end
`endif

            ST_DONE: begin
               busy_reg  <= 1'b0;
               err_reg   <= 1'b0;
               state_reg <= ST_IDLE;
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // Request strobes are masked by reset so they fall in the reset cycle itself.
   assign busy_o       = busy_reg;
   assign done_o       = done_reg;
   assign err_o        = err_reg;
   assign rtag_o       = rtag_reg;
   assign data_req_o   = req_reg & ~rst_i;
   assign data_we_o    = we_reg;
   assign data_be_o    = bus_be_reg;
   assign data_addr_o  = bus_addr_reg;
   assign data_wdata_o = bus_wdata_reg;
   assign data_wtag_o  = bus_wtag_reg;

`ifdef SPEC_MEM_REVOKE_EN
   assign rev_req_o  = rev_req_reg & ~rst_i;
   assign rev_addr_o = rev_addr_reg;
   assign revoked_o  = revoked_reg;
`else
   // Revocation path compiled out: response inputs are intentionally ignored.
   logic unused_rev;
   assign unused_rev = rev_valid_i ^ rev_bit_i;
   assign rev_req_o  = 1'b0;
   assign rev_addr_o = '0;
   assign revoked_o  = 1'b0;
`endif

endmodule

// File: tb/tb_spec_mem_sequencer.sv
// Testbench for spec_mem_sequencer: directed vector table, hand-written
// reset sequence and randomized operations against a behavioural model.
module tb_spec_mem_sequencer;
   localparam int NG  = 2;
   localparam int GWB = $clog2(NG + 1);
`ifdef SPEC_MEM_REVOKE_EN
   localparam int   REV_EXTRA = 3;
   localparam logic REV_ON    = 1'b1;
`else
   localparam int   REV_EXTRA = 0;
   localparam logic REV_ON    = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, start, is_write, is_cap, wtag;
   logic [GWB-1:0]   ngran;
   logic [NG*32-1:0] addr, wdata;
   logic [NG*4-1:0]  be;
   logic             busy, done, err, rtag, revoked;
   logic [NG*32-1:0] rdata;
   logic             data_req, data_gnt, data_we, data_wtag, data_rvalid, data_rtag, data_err;
   logic [3:0]       data_be;
   logic [31:0]      data_addr, data_wdata, data_rdata;
   logic             rev_req, rev_valid, rev_bit;
   logic [31:0]      rev_addr;

   int checks = 0;
   int errors = 0;

   spec_mem_sequencer #(.NGRAN(NG)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .is_write_i(is_write), .is_cap_i(is_cap),
      .ngran_i(ngran), .addr_i(addr), .wdata_i(wdata), .be_i(be), .wtag_i(wtag),
      .busy_o(busy), .done_o(done), .err_o(err), .rdata_o(rdata), .rtag_o(rtag),
      .revoked_o(revoked), .data_req_o(data_req), .data_gnt_i(data_gnt), .data_we_o(data_we),
      .data_be_o(data_be), .data_addr_o(data_addr), .data_wdata_o(data_wdata),
      .data_wtag_o(data_wtag), .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata),
      .data_rtag_i(data_rtag), .data_err_i(data_err), .rev_req_o(rev_req),
      .rev_addr_o(rev_addr), .rev_valid_i(rev_valid), .rev_bit_i(rev_bit)
   );

   typedef struct {
      logic        wr;
      logic        cap;
      logic [1:0]  n;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  be;
      logic        wtag;
      logic [63:0] rd;
      logic [1:0]  tags;
      logic [1:0]  errs;
      int          gdly;
      int          rlat;
   } op_t;

   typedef struct {
      logic        err;
      logic [63:0] rdata;
      logic        rtag;
      logic        revoked;
      int          lat;
      int          nreq;
   } res_t;

   typedef struct {
      op_t  op;
      res_t exp;
   } vec_t;

   // A response must never arrive in the same cycle as its grant.
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(data_gnt && data_rvalid))
         else begin
            errors++;
            $display("FAIL gnt_rvalid_overlap: got gnt=1 rvalid=1 expected not both");
         end
      end
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic op_t mk_op(input logic wr, input logic cap, input logic [1:0] n,
                                 input logic [63:0] a, input logic [63:0] wd, input logic [7:0] b,
                                 input logic wt, input logic [63:0] rd, input logic [1:0] tg,
                                 input logic [1:0] er, input int gd, input int rl);
      op_t o;
      o.wr = wr; o.cap = cap; o.n = n; o.addr = a; o.wdata = wd; o.be = b; o.wtag = wt;
      o.rd = rd; o.tags = tg; o.errs = er; o.gdly = gd; o.rlat = rl;
      return o;
   endfunction

   function automatic res_t mk_res(input logic e, input logic [63:0] rd, input logic rt,
                                   input logic rv, input int lat, input int nreq);
      res_t r;
      r.err = e; r.rdata = rd; r.rtag = rt; r.revoked = rv; r.lat = lat; r.nreq = nreq;
      return r;
   endfunction

   // Behavioural reference: outcome of a whole operation from the rules alone.
   function automatic res_t model(input op_t o, input logic [63:0] prev_rdata);
      res_t e;
      int   issued;
      logic tagacc;
      e = mk_res(1'b0, prev_rdata, 1'b0, 1'b0, 1, 0);
      if (o.n == 0) return e;
      if (int'(o.n) > NG) begin
         e.err = 1'b1;
         return e;
      end
      e.rdata = '0;
      tagacc  = 1'b1;
      issued  = 0;
      for (int i = 0; i < int'(o.n); i++) begin
         issued++;
         if (!o.wr) e.rdata[32*i +: 32] = o.rd[32*i +: 32];
         tagacc = tagacc & o.tags[i];
         if (o.errs[i]) begin
            e.err = 1'b1;
            break;
         end
      end
      e.nreq = issued;
      e.lat  = issued * (o.gdly + 1 + o.rlat) + 1;
      if (o.cap && !o.wr && !e.err && tagacc) begin
         e.rtag    = 1'b1;
         e.revoked = REV_ON;
         e.lat     = e.lat + REV_EXTRA;
      end
      return e;
   endfunction

   // Start one operation and act as bus slave until done_o; checks every request.
   task automatic run_op(input op_t o, output res_t r);
      int          cyc, nreq, resp_at, waited, pend_idx, rev_wait;
      logic        pending, seen, prev_req;
      logic [68:0] prev_bus;
      logic [68:0] cur_bus;
      r = mk_res(1'b0, '0, 1'b0, 1'b0, 0, 0);
      @(posedge clk); #1;
      start = 1'b1; is_write = o.wr; is_cap = o.cap; ngran = o.n;
      addr = o.addr; wdata = o.wdata; be = o.be; wtag = o.wtag;
      @(posedge clk); #1;
      // Scramble inputs: the sequencer must work from its latched copy.
      start = 1'b0; addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
      be = 8'($urandom); wtag = 1'($urandom); is_write = 1'($urandom); is_cap = 1'($urandom);
      cyc = 1; nreq = 0; resp_at = 0; waited = 0; pend_idx = 0; rev_wait = 0;
      pending = 1'b0; seen = 1'b0; prev_req = 1'b0; prev_bus = '0;
      while (!seen && cyc < 300) begin
         @(negedge clk);
         data_gnt = 1'b0; data_rvalid = 1'b0; data_err = 1'b0; rev_valid = 1'b0; start = 1'b0;
         data_rdata = $urandom; data_rtag = 1'($urandom);
         if (done) begin
            seen      = 1'b1;
            r.err     = err;
            r.rdata   = rdata;
            r.rtag    = rtag;
            r.revoked = revoked;
            r.lat     = cyc;
         end else begin
            chk("busy_during_op", busy, 1'b1);
            // Start pulses while busy must be ignored.
            if ($urandom_range(0, 3) == 0) begin
               start = 1'b1; ngran = GWB'($urandom_range(1, 2));
            end
            if (pending && cyc == resp_at) begin
               data_rvalid = 1'b1;
               data_rdata  = o.rd[32*pend_idx +: 32];
               data_rtag   = o.tags[pend_idx];
               data_err    = o.errs[pend_idx];
               pending     = 1'b0;
            end
            if (data_req) begin
               cur_bus = {data_addr, data_we, data_be, data_wdata};
               chk("one_outstanding", pending, 1'b0);
               if (prev_req) chk("req_stable", cur_bus, prev_bus);
               prev_bus = cur_bus;
               prev_req = 1'b1;
               if (waited >= o.gdly) begin
                  data_gnt = 1'b1;
                  if (nreq < int'(o.n)) begin
                     chk("req_fields", {data_addr, data_we, data_be, data_wdata, data_wtag},
                         {o.addr[32*nreq +: 32], o.wr, (o.cap ? 4'hF : o.be[4*nreq +: 4]),
                          o.wdata[32*nreq +: 32], (o.cap & o.wr & o.wtag)});
                  end else begin
                     chk("extra_request", nreq, o.n);
                  end
                  pend_idx = nreq;
                  nreq++;
                  pending  = 1'b1;
                  resp_at  = cyc + o.rlat;
                  waited   = 0;
                  prev_req = 1'b0;
               end else begin
                  waited++;
               end
            end
`ifdef SPEC_MEM_REVOKE_EN
            if (rev_req) begin
               chk("rev_addr", rev_addr, o.addr[31:0]);
               if (rev_wait == 2) begin
                  rev_valid = 1'b1;
                  rev_bit   = 1'b1;
               end
               rev_wait++;
            end
`else
            chk("rev_req_idle", rev_req, 1'b0);
`endif
         end
         cyc++;
      end
      start = 1'b0; data_gnt = 1'b0; data_rvalid = 1'b0; rev_valid = 1'b0;
      if (!seen) chk("done_timeout", 1'b0, 1'b1);
      r.nreq = nreq;
      @(negedge clk);
      chk("done_one_cycle", {done, busy}, 2'b00);
   endtask

   task automatic compare(input string tag, input res_t r, input res_t e);
      chk({tag, "_err"}, r.err, e.err);
      chk({tag, "_rdata"}, r.rdata, e.rdata);
      chk({tag, "_rtag"}, r.rtag, e.rtag);
      chk({tag, "_revoked"}, r.revoked, e.revoked);
      chk({tag, "_latency"}, r.lat, e.lat);
      chk({tag, "_nreq"}, r.nreq, e.nreq);
   endtask

   task automatic wait_req(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (data_req) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   vec_t        vecs [9];
   op_t         o;
   res_t        r, e;
   logic [63:0] prev_rdata;
   logic        ok;

   initial begin
      rst = 1'b1; start = 1'b0; is_write = 1'b0; is_cap = 1'b0; wtag = 1'b0; ngran = '0;
      addr = '0; wdata = '0; be = '0; data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0;
      data_rtag = 1'b0; data_err = 1'b0; rev_valid = 1'b0; rev_bit = 1'b0;

      // Directed table; expected outcomes worked out by hand.
      vecs[0] = '{mk_op(0, 0, 2'd1, 64'h0000_0000_8000_0010, 64'h0, 8'hFF, 0, 64'h0000_0000_DEAD_BEEF, 2'b11, 2'b00, 0, 1),
                  mk_res(0, 64'h0000_0000_DEAD_BEEF, 0, 0, 3, 1)};
      vecs[1] = '{mk_op(0, 1, 2'd2, 64'h0000_0104_0000_0100, 64'h0, 8'h00, 0, 64'h2222_2222_1111_1111, 2'b01, 2'b00, 0, 1),
                  mk_res(0, 64'h2222_2222_1111_1111, 0, 0, 5, 2)};
      vecs[2] = '{mk_op(1, 1, 2'd2, 64'h0000_0304_0000_0300, 64'hA5A5_A5A5_5A5A_5A5A, 8'h12, 1, 64'h0, 2'b11, 2'b00, 3, 1),
                  mk_res(0, 64'h0, 0, 0, 11, 2)};
      vecs[3] = '{mk_op(0, 0, 2'd2, 64'h0000_0020_0000_0010, 64'h0, 8'hFF, 0, 64'h3333_3333_4444_4444, 2'b11, 2'b01, 0, 1),
                  mk_res(1, 64'h0000_0000_4444_4444, 0, 0, 3, 1)};
      vecs[4] = '{mk_op(0, 0, 2'd3, 64'h0000_0040_0000_0030, 64'h0, 8'hFF, 0, 64'h0, 2'b11, 2'b00, 0, 1),
                  mk_res(1, 64'h0000_0000_4444_4444, 0, 0, 1, 0)};
      vecs[5] = '{mk_op(1, 0, 2'd0, 64'h0000_0040_0000_0030, 64'h1, 8'hFF, 0, 64'h0, 2'b11, 2'b00, 0, 1),
                  mk_res(0, 64'h0000_0000_4444_4444, 0, 0, 1, 0)};
      vecs[6] = '{mk_op(0, 1, 2'd2, 64'h0000_0508_0000_0500, 64'h0, 8'h00, 0, 64'hCAFE_F00D_0BAD_C0DE, 2'b11, 2'b00, 0, 1),
                  mk_res(0, 64'hCAFE_F00D_0BAD_C0DE, 1, REV_ON, 5 + REV_EXTRA, 2)};
      vecs[7] = '{mk_op(1, 0, 2'd1, 64'h0000_0000_0000_0600, 64'h0000_0000_1357_9BDF, 8'h03, 1, 64'h0, 2'b11, 2'b00, 0, 1),
                  mk_res(0, 64'h0, 0, 0, 3, 1)};
      vecs[8] = '{mk_op(0, 0, 2'd2, 64'h0000_0704_0000_0700, 64'h0, 8'hFF, 0, 64'h0F0F_0F0F_F0F0_F0F0, 2'b10, 2'b00, 1, 3),
                  mk_res(0, 64'h0F0F_0F0F_F0F0_F0F0, 0, 0, 11, 2)};

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_status", {busy, done, err, rdata, rtag, revoked}, '0);
      chk("reset_bus", {data_req, data_we, data_be, data_addr, data_wdata, data_wtag, rev_req, rev_addr}, '0);

      // Reset while waiting for the second granule's response.
      @(posedge clk); #1;
      start = 1'b1; is_write = 1'b0; is_cap = 1'b0; ngran = 2'd2;
      addr = 64'h0000_0204_0000_0200; be = 8'hFF;
      @(posedge clk); #1;
      start = 1'b0;
      wait_req(ok);
      chk("rst_seq_req0", {ok, data_addr}, {1'b1, 32'h0000_0200});
      data_gnt = 1'b1;
      @(negedge clk);
      data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = 32'h1234_5678; data_rtag = 1'b1; data_err = 1'b0;
      @(negedge clk);
      data_rvalid = 1'b0;
      wait_req(ok);
      chk("rst_seq_req1", {ok, data_addr}, {1'b1, 32'h0000_0204});
      data_gnt = 1'b1;
      @(negedge clk);
      data_gnt = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_status", {busy, done, err, rdata, rtag, revoked}, '0);
      chk("rst_mid_bus", {data_req, data_we, data_be, data_addr, data_wdata, data_wtag, rev_req, rev_addr}, '0);
      data_rvalid = 1'b1; data_rdata = 32'hFFFF_FFFF; data_rtag = 1'b1;
      @(negedge clk);
      data_rvalid = 1'b0;
      @(negedge clk);
      chk("stray_rvalid_ignored", {busy, done, data_req, rdata}, '0);
      $display("reset sequence: mid-op reset and stray response done");

      // Directed table.
      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].op, r);
         compare($sformatf("vec%0d", i), r, vecs[i].exp);
         $display("vec %0d: n=%0d wr=%0b cap=%0b lat=%0d err=%0b rtag=%0b", i, vecs[i].op.n,
                  vecs[i].op.wr, vecs[i].op.cap, r.lat, r.err, r.rtag);
      end
      prev_rdata = vecs[8].exp.rdata;

      // Randomized operations against the reference model.
      for (int t = 0; t < 40; t++) begin
         o.wr    = 1'($urandom);
         o.cap   = 1'($urandom);
         if ($urandom_range(0, 9) == 0)      o.n = 2'd0;
         else if ($urandom_range(0, 9) == 0) o.n = 2'd3;
         else                                o.n = 2'($urandom_range(1, 2));
         o.addr  = {$urandom, $urandom};
         o.wdata = {$urandom, $urandom};
         o.be    = 8'($urandom);
         o.wtag  = 1'($urandom);
         o.rd    = {$urandom, $urandom};
         o.tags  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
         o.errs  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         o.gdly  = $urandom_range(0, 3);
         o.rlat  = $urandom_range(1, 3);
         e = model(o, prev_rdata);
         run_op(o, r);
         compare($sformatf("rnd%0d", t), r, e);
         $display("rnd %0d: n=%0d wr=%0b cap=%0b lat=%0d err=%0b rtag=%0b", t, o.n, o.wr, o.cap,
                  r.lat, r.err, r.rtag);
         prev_rdata = e.rdata;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
